// File: rtl/mipi_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mipi_cal_pkg
// Description : Shared constants and FSM state encoding for the MIPI PHY
//               input-delay calibration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mipi_cal_pkg;

    localparam int         c_TAP_W    = 5;
    localparam int         c_NUM_TAPS = 32;
    localparam logic [7:0] c_SAT8_MAX = 8'd255;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LOAD    = 3'd1;
    localparam logic [2:0] c_ST_SETTLE  = 3'd2;
    localparam logic [2:0] c_ST_MEASURE = 3'd3;
    localparam logic [2:0] c_ST_EVAL    = 3'd4;
    localparam logic [2:0] c_ST_APPLY   = 3'd5;
    localparam logic [2:0] c_ST_FINISH  = 3'd6;

endpackage
`default_nettype wire

// File: rtl/mipi_cal_run_tracker.sv
`default_nettype none
// ============================================================================
// Module      : mipi_cal_run_tracker
// Description : Tracks the current and longest contiguous run of passing taps
//               and reports the centre of the longest (earliest on ties) run.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_cal_run_tracker
    import mipi_cal_pkg::*;
#(
    parameter int TAP_W = c_TAP_W
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             eval_en,
    input  logic             pass,
    input  logic [TAP_W-1:0] tap,
    output logic [TAP_W:0]   best_len,
    output logic [TAP_W-1:0] centre
);

    localparam logic [TAP_W:0] c_LEN_ONE = {{TAP_W{1'b0}}, 1'b1};

    logic [TAP_W-1:0] r_cur_start;
    logic [TAP_W-1:0] r_best_start;
    logic [TAP_W:0]   r_cur_len;
    logic [TAP_W:0]   r_best_len;
    logic [TAP_W-1:0] w_run_start;
    logic [TAP_W:0]   w_run_len;

    assign w_run_start = (r_cur_len == '0) ? tap : r_cur_start;
    assign w_run_len   = r_cur_len + c_LEN_ONE;

    // Strict comparison keeps the earliest run when lengths tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (clear) begin
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
        end else if (eval_en) begin
            if (pass) begin
                r_cur_start <= w_run_start;
                r_cur_len   <= w_run_len;
                if (w_run_len > r_best_len) begin
                    r_best_start <= w_run_start;
                    r_best_len   <= w_run_len;
                end
            end else begin
                r_cur_len <= '0;
            end
        end
    end

    assign best_len = r_best_len;
    assign centre   = TAP_W'({1'b0, r_best_start} + ((r_best_len - c_LEN_ONE) >> 1));

endmodule
`default_nettype wire

// File: rtl/mipi_delay_cal.sv
`default_nettype none
// ============================================================================
// Module      : mipi_delay_cal
// Description : Sweeps the data-lane IDELAY tap, scores sync-byte lock per tap
//               and loads the centre of the widest passing window.
// Revision    : 1.0 - initial release
// ============================================================================
module mipi_delay_cal
    import mipi_cal_pkg::*;
#(
    parameter int TAP_W         = c_TAP_W,
    parameter int NUM_TAPS      = c_NUM_TAPS,
    parameter int SETTLE_CYCLES = 64,
    parameter int WIN_W         = 16
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [TAP_W-1:0]    del_val_clk_cfg,
    input  logic [WIN_W-1:0]    dwell_cycles,
    input  logic [7:0]          min_hits,
    input  logic                sot_pulse,
    input  logic                sync_pulse,
    output logic                del_ld,
    output logic [TAP_W-1:0]    del_val_dat,
    output logic [TAP_W-1:0]    del_val_clk,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [TAP_W-1:0]    best_tap,
    output logic [TAP_W:0]      eye_width,
    output logic [NUM_TAPS-1:0] pass_map
);

    localparam logic [WIN_W-1:0] c_CNT_ONE     = WIN_W'(1);
    localparam logic [WIN_W-1:0] c_SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0] c_TAP_ONE     = TAP_W'(1);
    localparam logic [TAP_W-1:0] c_LAST_TAP    = TAP_W'(NUM_TAPS - 1);

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [WIN_W-1:0]    r_cnt;
    logic [TAP_W-1:0]    r_tap;
    logic [TAP_W-1:0]    r_dat_hold;
    logic [TAP_W-1:0]    r_del_val_clk;
    logic [7:0]          r_sot_cnt;
    logic [7:0]          r_hit_cnt;
    logic                r_done;
    logic                r_fail;
    logic [TAP_W-1:0]    r_best_tap;
    logic [TAP_W:0]      r_eye_width;
    logic [NUM_TAPS-1:0] r_pass_map;

    logic                w_start_ok;
    logic [WIN_W-1:0]    w_dwell_last;
    logic                w_settle_done;
    logic                w_measure_done;
    logic                w_last_tap;
    logic [7:0]          w_min_hits;
    logic                w_pass;
    logic [TAP_W:0]      w_best_len;
    logic [TAP_W-1:0]    w_centre;
    logic [TAP_W-1:0]    w_apply_tap;

    assign w_start_ok     = start && !abort && (r_state == c_ST_IDLE);
    assign w_dwell_last   = (dwell_cycles == '0) ? '0 : dwell_cycles - c_CNT_ONE;
    assign w_settle_done  = (r_cnt == c_SETTLE_LAST);
    assign w_measure_done = (r_cnt == w_dwell_last);
    assign w_last_tap     = (r_tap == c_LAST_TAP);
    assign w_min_hits     = (min_hits == 8'd0) ? 8'd1 : min_hits;
    assign w_pass         = (r_hit_cnt >= w_min_hits) && (r_hit_cnt >= r_sot_cnt);
    assign w_apply_tap    = (w_best_len != '0) ? w_centre : '0;

    mipi_cal_run_tracker #(
        .TAP_W (TAP_W)
    ) u_tracker (
        .clk      (clk),
        .reset    (reset),
        .clear    (w_start_ok),
        .eval_en  ((r_state == c_ST_EVAL) && !abort),
        .pass     (w_pass),
        .tap      (r_tap),
        .best_len (w_best_len),
        .centre   (w_centre)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (abort && (r_state != c_ST_IDLE)) begin
            w_next = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE:    if (w_start_ok)     w_next = c_ST_LOAD;
                c_ST_LOAD:                        w_next = c_ST_SETTLE;
                c_ST_SETTLE:  if (w_settle_done)  w_next = c_ST_MEASURE;
                c_ST_MEASURE: if (w_measure_done) w_next = c_ST_EVAL;
                c_ST_EVAL:    w_next = w_last_tap ? c_ST_APPLY : c_ST_LOAD;
                c_ST_APPLY:                       w_next = c_ST_FINISH;
                c_ST_FINISH:  if (w_settle_done)  w_next = c_ST_IDLE;
                default:                          w_next = c_ST_IDLE;
            endcase
        end
    end

    // The load value is presented in the same cycle as its strobe and then held.
    always_comb begin
        busy        = (r_state != c_ST_IDLE);
        del_ld      = (r_state == c_ST_LOAD) || (r_state == c_ST_APPLY);
        del_val_dat = r_dat_hold;
        if (r_state == c_ST_LOAD)       del_val_dat = r_tap;
        else if (r_state == c_ST_APPLY) del_val_dat = w_apply_tap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    r_cnt <= '0;
        else if (w_next != r_state)   r_cnt <= '0;
        else if ((r_state == c_ST_SETTLE) || (r_state == c_ST_MEASURE) ||
                 (r_state == c_ST_FINISH))
                                      r_cnt <= r_cnt + c_CNT_ONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sot_cnt <= 8'd0;
            r_hit_cnt <= 8'd0;
        end else if (r_state == c_ST_LOAD) begin
            r_sot_cnt <= 8'd0;
            r_hit_cnt <= 8'd0;
        end else if (r_state == c_ST_MEASURE) begin
            if (sot_pulse  && (r_sot_cnt != c_SAT8_MAX)) r_sot_cnt <= r_sot_cnt + 8'd1;
            if (sync_pulse && (r_hit_cnt != c_SAT8_MAX)) r_hit_cnt <= r_hit_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tap         <= '0;
            r_dat_hold    <= '0;
            r_del_val_clk <= '0;
            r_done        <= 1'b0;
            r_fail        <= 1'b0;
            r_best_tap    <= '0;
            r_eye_width   <= '0;
            r_pass_map    <= '0;
        end else begin
            if (del_ld) r_dat_hold <= del_val_dat;
            if (w_start_ok) begin
                r_tap         <= '0;
                r_del_val_clk <= del_val_clk_cfg;
                r_pass_map    <= '0;
                r_done        <= 1'b0;
                r_fail        <= 1'b0;
            end else if (!abort) begin
                case (r_state)
                    c_ST_EVAL: begin
                        r_pass_map[r_tap] <= w_pass;
                        if (!w_last_tap) r_tap <= r_tap + c_TAP_ONE;
                    end
                    c_ST_APPLY: begin
                        r_best_tap  <= w_apply_tap;
                        r_eye_width <= w_best_len;
                        r_fail      <= (w_best_len == '0);
                    end
                    c_ST_FINISH: if (w_settle_done) r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign del_val_clk = r_del_val_clk;
    assign done        = r_done;
    assign fail        = r_fail;
    assign best_tap    = r_best_tap;
    assign eye_width   = r_eye_width;
    assign pass_map    = r_pass_map;

endmodule
`default_nettype wire

// File: tb/tb_mipi_delay_cal.sv
`default_nettype none
// ============================================================================
// Module      : tb_mipi_delay_cal
// Description : Randomised self-checking bench for mipi_delay_cal with a
//               window-scoring reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mipi_delay_cal;

    localparam int TAP_W    = 5;
    localparam int NUM_TAPS = 32;
    localparam int SETTLE   = 16;
    localparam int WIN_W    = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [TAP_W-1:0]    del_val_clk_cfg = '0;
    logic [WIN_W-1:0]    dwell_cycles = '0;
    logic [7:0]          min_hits = '0;
    logic                sot_pulse = 1'b0;
    logic                sync_pulse = 1'b0;
    logic                del_ld;
    logic [TAP_W-1:0]    del_val_dat;
    logic [TAP_W-1:0]    del_val_clk;
    logic                busy;
    logic                done;
    logic                fail;
    logic [TAP_W-1:0]    best_tap;
    logic [TAP_W:0]      eye_width;
    logic [NUM_TAPS-1:0] pass_map;

    always #5 clk = ~clk;

    mipi_delay_cal #(
        .TAP_W (TAP_W), .NUM_TAPS (NUM_TAPS), .SETTLE_CYCLES (SETTLE), .WIN_W (WIN_W)
    ) dut (
        .clk (clk), .reset (reset), .start (start), .abort (abort),
        .del_val_clk_cfg (del_val_clk_cfg), .dwell_cycles (dwell_cycles),
        .min_hits (min_hits), .sot_pulse (sot_pulse), .sync_pulse (sync_pulse),
        .del_ld (del_ld), .del_val_dat (del_val_dat), .del_val_clk (del_val_clk),
        .busy (busy), .done (done), .fail (fail), .best_tap (best_tap),
        .eye_width (eye_width), .pass_map (pass_map)
    );

    int errors = 0;
    int checks = 0;
    int sot_n [NUM_TAPS];
    int syn_n [NUM_TAPS];
    int sot_left, syn_left, ld_count;
    logic [NUM_TAPS-1:0] m_map;
    int m_best, m_eye;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-tap verdict from saturated counts, then brute-force longest run search.
    function automatic void build_model(input int minh);
        int thr, h, s, len, bl, bs;
        thr = (minh == 0) ? 1 : minh;
        for (int t = 0; t < NUM_TAPS; t++) begin
            h = (syn_n[t] > 255) ? 255 : syn_n[t];
            s = (sot_n[t] > 255) ? 255 : sot_n[t];
            m_map[t] = (h >= thr) && (h >= s);
        end
        bl = 0;
        bs = 0;
        for (int a = 0; a < NUM_TAPS; a++) begin
            len = 0;
            while ((a + len < NUM_TAPS) && m_map[a + len]) len++;
            if (len > bl) begin
                bl = len;
                bs = a;
            end
        end
        m_eye  = bl;
        m_best = (bl > 0) ? bs + (bl - 1) / 2 : 0;
    endfunction

    task automatic set_profile(input int lo, input int hi, input int si, input int yi,
                               input int so, input int yo);
        for (int t = 0; t < NUM_TAPS; t++) begin
            sot_n[t] = (t >= lo && t <= hi) ? si : so;
            syn_n[t] = (t >= lo && t <= hi) ? yi : yo;
        end
    endtask

    // Drives the pulses belonging to cycle n of a sweep; only measure cycles carry the profile.
    task automatic drive_cycle(input int n, input int d);
        int p, k, r, i, rem;
        p = SETTLE + d + 2;
        k = (n - 1) / p;
        r = (n - 1) % p;
        start = (n == p + 3);
        if (k < NUM_TAPS && r >= SETTLE + 1 && r <= SETTLE + d) begin
            i   = r - SETTLE - 1;
            rem = d - i;
            sot_pulse  = ($urandom_range(0, rem - 1) < sot_left);
            sync_pulse = ($urandom_range(0, rem - 1) < syn_left);
            if (sot_pulse)  sot_left--;
            if (sync_pulse) syn_left--;
        end else begin
            if (k < NUM_TAPS && r == 0) begin
                sot_left = sot_n[k];
                syn_left = syn_n[k];
            end
            sot_pulse  = $urandom_range(0, 1) == 1;
            sync_pulse = $urandom_range(0, 1) == 1;
        end
    endtask

    task automatic check_cycle(input int n, input int d);
        int p, k;
        logic [2:0] e;
        p = SETTLE + d + 2;
        e[2] = (n >= 1) && (n <= NUM_TAPS * p + 1) && ((n - 1) % p == 0);
        e[1] = (n <= NUM_TAPS * p + 1 + SETTLE);
        e[0] = (n >  NUM_TAPS * p + 1 + SETTLE);
        chk("ctrl{ld,busy,done}", {del_ld, busy, done}, e);
        if (del_ld) ld_count++;
        if (e[2]) begin
            k = (n - 1) / p;
            chk("ld_val", del_val_dat, (k < NUM_TAPS) ? k : m_best);
        end
    endtask

    task automatic begin_sweep(input int dw, input int minh, output logic [TAP_W-1:0] cfg);
        dwell_cycles    = WIN_W'(dw);
        min_hits        = 8'(minh);
        cfg             = TAP_W'($urandom);
        del_val_clk_cfg = cfg;
        build_model(minh);
        ld_count = 0;
        @(negedge clk);
        start = 1'b1;
        sot_pulse = 1'b0;
        sync_pulse = 1'b0;
        @(negedge clk);
        del_val_clk_cfg = ~cfg;
    endtask

    task automatic run_cal(input string tag, input int dw, input int minh);
        int d, nb;
        logic [TAP_W-1:0] cfg;
        d  = (dw == 0) ? 1 : dw;
        nb = NUM_TAPS * (SETTLE + d + 2) + 1 + SETTLE;
        begin_sweep(dw, minh, cfg);
        for (int n = 1; n <= nb + 1; n++) begin
            check_cycle(n, d);
            drive_cycle(n, d);
            if (n <= nb) @(negedge clk);
        end
        start = 1'b0;
        sot_pulse = 1'b0;
        sync_pulse = 1'b0;
        chk({tag, ".pass_map"}, pass_map, m_map);
        chk({tag, ".best_tap"}, best_tap, m_best);
        chk({tag, ".eye_width"}, eye_width, m_eye);
        chk({tag, ".fail"}, fail, m_eye == 0);
        chk({tag, ".dat_hold"}, del_val_dat, m_best);
        chk({tag, ".clk_tap"}, del_val_clk, cfg);
        chk({tag, ".ld_count"}, ld_count, NUM_TAPS + 1);
    endtask

    task automatic abort_test();
        int an, cnt;
        logic [TAP_W-1:0] cfg;
        set_profile(10, 20, 4, 4, 4, 0);
        begin_sweep(12, 2, cfg);
        an = 7 * (SETTLE + 14) + 1 + SETTLE + 4;
        for (int n = 1; n <= an; n++) begin
            check_cycle(n, 12);
            drive_cycle(n, 12);
            if (n < an) @(negedge clk);
        end
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        sot_pulse = 1'b0;
        sync_pulse = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.done", done, 1'b0);
        chk("abort.fail", fail, 1'b0);
        chk("abort.dat", del_val_dat, 7);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (del_ld || busy) cnt++;
        end
        chk("abort.quiet", cnt, 0);
    endtask

    task automatic reset_test();
        int lc;
        logic [TAP_W-1:0] cfg;
        set_profile(0, 31, 1, 2, 0, 0);
        begin_sweep(6, 1, cfg);
        lc = 3 * (SETTLE + 8) + 1;
        for (int n = 1; n <= lc; n++) begin
            check_cycle(n, 6);
            drive_cycle(n, 6);
            if (n < lc) @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("rst.outs", {del_ld, busy, done, fail, del_val_dat, del_val_clk, best_tap, eye_width},
            '0);
        chk("rst.pass_map", pass_map, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int d, a, b;
        repeat (2) @(negedge clk);
        chk("reset.ctrl", {del_ld, busy, done, fail}, 4'b0000);
        chk("reset.vals", {del_val_dat, del_val_clk, best_tap, eye_width, pass_map}, '0);
        reset = 1'b0;
        @(negedge clk);

        set_profile(10, 20, 4, 4, 4, 0);
        run_cal("win10_20", 12, 2);
        chk("win10_20.lit_map", pass_map, 32'h001F_FC00);
        chk("win10_20.lit_best", best_tap, 15);
        chk("win10_20.lit_eye", eye_width, 11);

        set_profile(3, 6, 2, 2, 2, 0);
        for (int t = 20; t <= 23; t++) syn_n[t] = 2;
        run_cal("two_win", 8, 1);
        chk("two_win.lit_best", best_tap, 4);
        chk("two_win.model_eye", m_eye, 4);

        set_profile(28, 31, 3, 3, 3, 1);
        run_cal("top_edge", 8, 2);
        chk("top_edge.lit_best", best_tap, 29);
        chk("top_edge.lit_eye", eye_width, 4);

        set_profile(0, -1, 0, 0, 2, 0);
        run_cal("no_sync", 6, 1);
        chk("no_sync.lit", {done, fail, best_tap, eye_width}, {1'b1, 1'b1, 5'd0, 6'd0});

        set_profile(12, 14, 4, 4, 2, 0);
        for (int t = 5; t <= 9; t++) begin
            sot_n[t] = 4;
            syn_n[t] = 3;
        end
        run_cal("hit_lt_sot", 10, 1);
        chk("hit_lt_sot.lit_map", pass_map, 32'h0000_7000);
        chk("hit_lt_sot.lit_best", best_tap, 13);

        set_profile(2, 4, 0, 1, 0, 0);
        run_cal("minh0_dwell0", 0, 0);
        chk("minh0_dwell0.lit_map", pass_map, 32'h0000_001C);
        chk("minh0_dwell0.lit_best", best_tap, 3);

        set_profile(0, 9, 270, 260, 270, 100);
        run_cal("saturate", 270, 1);
        chk("saturate.lit_map", pass_map, 32'h0000_03FF);
        chk("saturate.lit_best", best_tap, 4);

        abort_test();
        set_profile(10, 20, 4, 4, 4, 0);
        run_cal("after_abort", 12, 2);

        for (int r = 0; r < 3; r++) begin
            d = $urandom_range(1, 20);
            a = $urandom_range(0, 31);
            b = a + $urandom_range(0, 12);
            for (int t = 0; t < NUM_TAPS; t++) begin
                sot_n[t] = $urandom_range(0, d / 2);
                syn_n[t] = (t >= a && t <= b) ? $urandom_range(sot_n[t], d) : $urandom_range(0, d);
            end
            run_cal("random", d, $urandom_range(0, 4));
        end

        reset_test();
        set_profile(5, 9, 3, 3, 3, 0);
        run_cal("after_reset", 7, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
